uart_tx_arbiter: RTL and testbench

//  Shares one uart_tx transmitter between N_REQ byte sources, each a queue

---
 rtl/uart_arb_pkg.sv | 9 +
 rtl/rr_pick.sv | 22 ++
 rtl/uart_tx_arbiter.sv | 99 +++++++++
 tb/tb_uart_tx_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encodings and defaults for the uart_tx arbiter
package uart_arb_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAG  = 2'd1,
        ST_SEND = 2'd2
    } state_t;
    localparam logic [7:0] TAG_BASE_DEF = 8'hF0;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority encoder, first set bit at or after ptr
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         any,
    output logic [W-1:0] idx
);
    always_comb begin
        any = |req;
        idx = '0;
        // descending scan so the candidate closest to ptr is assigned last
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = int'(ptr) + k;
            j = (j >= N) ? j - N : j;
            if (req[j]) idx = W'(j);
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin burst arbiter sharing one uart_tx; tag byte per grant with UART_TX_ARBITER_TAG_EN
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         N_REQ    = 4,
    parameter int         BURST    = 8,
    parameter logic [7:0] TAG_BASE = TAG_BASE_DEF,
    localparam int        IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int        CNT_W    = (BURST > 1) ? $clog2(BURST + 1) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_avail,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ack,
    output logic               tx_en,
    output logic [7:0]         tx_data,
    input  logic               tx_ack,
    output logic               grant_vld,
    output logic [IDX_W-1:0]   grant_idx
);
    state_t           state, state_n;
    logic [IDX_W-1:0] grant, grant_n, ptr, ptr_n, pick;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             any, cur_avail, done;
    logic [7:0]       cur_data;

    rr_pick #(.N(N_REQ), .W(IDX_W)) u_pick (
        .req(req_avail),
        .ptr(ptr),
        .any(any),
        .idx(pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            grant <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        cur_data = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grant == IDX_W'(i)) cur_data = req_data[8*i +: 8];
        cur_avail = req_avail[grant];
        // exit (b) only when no ack is in flight, so the acked byte is never orphaned
        done      = (tx_ack && cnt == CNT_W'(BURST - 1)) || (!cur_avail && !tx_ack);
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        ptr_n   = ptr;
        cnt_n   = cnt;
        tx_en   = 1'b0;
        tx_data = '0;
        req_ack = '0;
        case (state)
            ST_IDLE: begin
                if (any) begin
`ifdef UART_TX_ARBITER_TAG_EN
                    state_n = ST_TAG;
`else
                    state_n = ST_SEND;
`endif
                    grant_n = pick;
                    cnt_n   = '0;
                end
            end
            ST_TAG: begin
                tx_en   = 1'b1;
                tx_data = TAG_BASE + 8'(grant);
                state_n = tx_ack ? ST_SEND : ST_TAG;
            end
            ST_SEND: begin
                tx_en   = cur_avail;
                tx_data = cur_data;
                req_ack = tx_ack ? (N_REQ'(1) << grant) : '0;
                cnt_n   = tx_ack ? cnt + 1'b1 : cnt;
                if (done) begin
                    state_n = ST_IDLE;
                    ptr_n   = (grant == IDX_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign grant_vld = (state != ST_IDLE);
    assign grant_idx = grant_vld ? grant : '0;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter (BURST=8 and BURST=1 instances)
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int B = 8;

    typedef struct {
        int         src;
        logic       tag;
        logic [7:0] b;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   req_avail, req_ack;
    logic [8*N-1:0] req_data;
    logic           tx_en, tx_ack, grant_vld;
    logic [7:0]     tx_data;
    logic [1:0]     grant_idx;

    logic [N-1:0]   req_ack1;
    logic           tx_en1, tx_ack1, gv1;
    logic [7:0]     tx_data1;
    logic [1:0]     gi1;

    uart_tx_arbiter #(.N_REQ(N), .BURST(B), .TAG_BASE(8'hF0)) dut (
        .clk(clk), .rst(rst), .req_avail(req_avail), .req_data(req_data),
        .req_ack(req_ack), .tx_en(tx_en), .tx_data(tx_data), .tx_ack(tx_ack),
        .grant_vld(grant_vld), .grant_idx(grant_idx)
    );

    uart_tx_arbiter #(.N_REQ(N), .BURST(1), .TAG_BASE(8'hF0)) dut1 (
        .clk(clk), .rst(rst), .req_avail(4'hF), .req_data(32'h13121110),
        .req_ack(req_ack1), .tx_en(tx_en1), .tx_data(tx_data1), .tx_ack(tx_ack1),
        .grant_vld(gv1), .grant_idx(gi1)
    );

    int total = 0;
    int bad = 0;

    logic [7:0] qm[N][$];
    logic       m3 = 1'b1;
    ent_t       exp_q[$];
    int         mptr = 0;
    logic [7:0] obs_b[$];
    int         obs_s[$];
    logic [7:0] tag_b[$];

    logic [N-1:0] ra, ra1;
    logic         ta, te, ta1, te1, pgv1;
    int           busy = 0, gap = 0, e1 = 0, acks1 = 0, acks1_total = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", n, a, e);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            req_avail[i]      = (qm[i].size() > 0) && (i != 3 || m3);
            req_data[8*i +: 8] = (qm[i].size() > 0) ? qm[i][0] : 8'h00;
        end
    endtask

    // expected byte stream from queue contents: rotate from mptr, up to B bytes per grant
    task automatic build(input logic [N-1:0] use_mask);
        int c[N];
        int p[N];
        int left, g, n;
        left = 0;
        for (int i = 0; i < N; i++) begin
            c[i] = use_mask[i] ? qm[i].size() : 0;
            p[i] = 0;
            left += c[i];
        end
        while (left > 0) begin
            g = mptr;
            while (c[g] == 0) g = (g + 1) % N;
`ifdef UART_TX_ARBITER_TAG_EN
            exp_q.push_back('{src: g, tag: 1'b1, b: 8'(8'hF0 + g)});
`endif
            n = (c[g] < B) ? c[g] : B;
            for (int k = 0; k < n; k++) exp_q.push_back('{src: g, tag: 1'b0, b: qm[g][p[g] + k]});
            p[g] += n;
            c[g] -= n;
            left -= n;
            mptr = (g + 1) % N;
        end
    endtask

    task automatic load(input int i, input logic [7:0] b0, input int n);
        for (int k = 0; k < n; k++) qm[i].push_back(8'(b0 + k));
    endtask

    task automatic clear_obs();
        obs_b.delete();
        obs_s.delete();
        tag_b.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst    = 1'b1;
        tx_ack = 1'b0;
        #1;
        chk("rst_grant_vld", 32'(grant_vld), 0);
        chk("rst_tx_en", 32'(tx_en), 0);
        chk("rst_req_ack", 32'(req_ack), 0);
        for (int i = 0; i < N; i++) qm[i].delete();
        exp_q.delete();
        mptr = 0;
        m3   = 1'b1;
        refresh();
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic wait_obs(input int n);
        int t;
        t = 0;
        while (obs_b.size() < n && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk("wait_obs_timeout", 32'(obs_b.size() >= n), 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && !grant_vld) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        chk("drain_left", 32'(exp_q.size()), 0);
    endtask

    // single compare process: samples at negedge, advances the queue and uart_tx models after posedge
    always begin
        @(negedge clk);
        ra  = req_ack;
        ta  = tx_ack;
        te  = tx_en;
        ra1 = req_ack1;
        ta1 = tx_ack1;
        te1 = tx_en1;
        if (!rst) begin
            if (ta) begin
                chk("ack_expected", 32'(exp_q.size() > 0), 1);
                chk("tx_en_at_ack", 32'(te), 1);
                if (exp_q.size() > 0) begin
                    ent_t e;
                    e = exp_q.pop_front();
                    chk("tx_data", 32'(tx_data), 32'(e.b));
                    chk("req_ack", 32'(ra), e.tag ? 0 : (32'd1 << e.src));
                    chk("grant_idx", 32'(grant_idx), 32'(e.src));
                    if (e.tag) tag_b.push_back(tx_data);
                    else begin
                        obs_b.push_back(tx_data);
                        obs_s.push_back(int'(grant_idx));
                    end
                end
            end else chk("req_ack_quiet", 32'(ra), 0);
            if (!grant_vld) chk("tx_en_idle", 32'(te), 0);
            if (ta1) begin
                chk("b1_grant_idx", 32'(gi1), 32'(e1));
                chk("b1_req_ack", 32'(ra1), 32'd1 << e1);
                chk("b1_tx_data", 32'(tx_data1), 32'h10 + 32'(e1));
                e1 = (e1 + 1) % N;
                acks1++;
                acks1_total++;
            end
            if (pgv1 && !gv1) begin
                chk("b1_one_ack", 32'(acks1), 1);
                acks1 = 0;
            end
            pgv1 = gv1;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            tx_ack  = 1'b0;
            tx_ack1 = 1'b0;
            busy    = 0;
            e1      = 0;
            acks1   = 0;
            pgv1    = 1'b0;
        end else begin
            for (int i = 0; i < N; i++)
                if (ra[i] && qm[i].size() > 0) void'(qm[i].pop_front());
            refresh();
            if (ta) begin
                tx_ack = 1'b0;
                busy   = gap;
                gap    = (gap + 1) % 3;
            end else if (busy > 0) busy--;
            else if (te) tx_ack = 1'b1;
            tx_ack1 = ta1 ? 1'b0 : te1;
        end
    end

    initial begin
        tx_ack  = 1'b0;
        tx_ack1 = 1'b0;
        refresh();
        @(negedge clk);
        chk("init_grant_vld", 32'(grant_vld), 0);
        chk("init_tx_en", 32'(tx_en), 0);
        chk("init_req_ack", 32'(req_ack), 0);
        @(posedge clk);
        #3;
        rst = 1'b0;

        // 1: async reset mid-SEND, then lowest available index wins
        @(posedge clk);
        #2;
        clear_obs();
        load(0, 8'h30, 6);
        refresh();
        build(4'hF);
        wait_obs(2);
        do_reset();
        @(posedge clk);
        #2;
        clear_obs();
        load(3, 8'hA3, 1);
        load(1, 8'hA1, 1);
        refresh();
        build(4'hF);
        drain();
        chk("t1_first_src", 32'(obs_s.size() > 0 ? obs_s[0] : -1), 1);

        // 2: only req 2 with 41,42,43; ptr afterwards at 3
        @(posedge clk);
        #2;
        clear_obs();
        load(2, 8'h41, 3);
        refresh();
        build(4'hF);
        drain();
        chk("t2_len", 32'(obs_b.size()), 3);
        for (int k = 0; k < 3 && k < obs_b.size(); k++) begin
            chk("t2_byte", 32'(obs_b[k]), 32'h41 + 32'(k));
            chk("t2_src", 32'(obs_s[k]), 2);
        end
        @(posedge clk);
        #2;
        clear_obs();
        load(0, 8'h01, 1);
        load(3, 8'h03, 1);
        refresh();
        build(4'hF);
        drain();
        chk("t2_ptr3_first", 32'(obs_s.size() > 0 ? obs_s[0] : -1), 3);

        // 3: reqs 0 and 1 with 12 bytes each, bursts of 8 then 4
        do_reset();
        @(posedge clk);
        #2;
        clear_obs();
        load(0, 8'h00, 12);
        load(1, 8'h80, 12);
        refresh();
        build(4'hF);
        drain();
        chk("t3_len", 32'(obs_b.size()), 24);
        if (obs_b.size() == 24) begin
            chk("t3_s7", 32'(obs_s[7]), 0);
            chk("t3_s8", 32'(obs_s[8]), 1);
            chk("t3_s15", 32'(obs_s[15]), 1);
            chk("t3_s16", 32'(obs_s[16]), 0);
            chk("t3_s20", 32'(obs_s[20]), 1);
            chk("t3_b16", 32'(obs_b[16]), 32'h08);
            chk("t3_b23", 32'(obs_b[23]), 32'h8B);
        end

        // 5: req 3 drops avail while req 0 bursts
        do_reset();
        @(posedge clk);
        #2;
        clear_obs();
        load(0, 8'hC0, 5);
        load(3, 8'hD0, 2);
        refresh();
        build(4'b0001);
        wait_obs(1);
        m3 = 1'b0;
        refresh();
        drain();
        chk("t5_len", 32'(obs_b.size()), 5);
        chk("t5_last", 32'(obs_b.size() == 5 ? obs_b[4] : 8'h00), 32'hC4);
        qm[3].delete();
        m3 = 1'b1;
        refresh();

`ifdef UART_TX_ARBITER_TAG_EN
        // 6: tag F1 precedes the single payload byte 55
        do_reset();
        @(posedge clk);
        #2;
        clear_obs();
        load(1, 8'h55, 1);
        refresh();
        build(4'hF);
        drain();
        chk("t6_tag", 32'(tag_b.size() > 0 ? tag_b[0] : 8'h00), 32'hF1);
        chk("t6_data", 32'(obs_b.size() > 0 ? obs_b[0] : 8'h00), 32'h55);
        chk("t6_len", 32'(obs_b.size() + tag_b.size()), 2);
`endif

        // 4: BURST=1 instance has been cycling 0,1,2,3 with all sources available
        chk("t4_acks_seen", 32'(acks1_total >= 8), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
